ifmap_streamer: RTL
===================

# ifmap_streamer

Feeds input feature-map planes into `conv2d_universal`. It reads pixels from the ifmap SRAM, which has a 1-cycle read latency. For each channel plane it issues the conv start pulse, then drives one pixel per cycle in raster order. It waits for the conv engine's done before sending the next plane. It sits between the ifmap buffer and the conv core, in place of the hand-driven stimulus used in unit benches.

## Interface
Parameters:
- `DATA_WIDTH`, 16: pixel width (signed Q8.8).
- `ADDR_WIDTH`, 20: SRAM word-address width.

Ports:
- `i_clk`, in, 1: clock.
- `i_rst`, in, 1: reset. One clock; reset is synchronous and active-low.
- `i_cmd_valid`, in, 1: command request.
- `o_cmd_ready`, out, 1: high only in IDLE.
- `i_base_addr`, in, ADDR_WIDTH: address of pixel (ch0, row0, col0).
- `i_width`, in, 9: plane width W.
- `i_height`, in, 9: plane height H.
- `i_num_ch`, in, 10: number of planes C.
- `o_mem_en`, out, 1: SRAM read enable.
- `o_mem_addr`, out, ADDR_WIDTH: SRAM read address.
- `i_mem_rdata`, in, DATA_WIDTH: read data, valid the cycle after `o_mem_en`.
- `o_conv_start`, out, 1: 1-cycle start pulse to the conv core, one per plane.
- `o_data`, out, DATA_WIDTH: pixel to the conv core.
- `o_valid`, out, 1: `o_data` is valid.
- `i_conv_done`, in, 1: conv core finished the current plane.
- `o_busy`, out, 1: high whenever the state is not IDLE.
- `o_done`, out, 1: 1-cycle pulse when the whole command is complete.

## Operation
- Layout is contiguous. Pixel (c, r, x) is at `base + c*W*H + r*W + x`. The address is produced by a running counter, with no multiplier. It wraps modulo 2^ADDR_WIDTH.
- Command fields are latched on accept (`i_cmd_valid && o_cmd_ready`). Input changes while busy are ignored.
- States:
  - IDLE → START on accept. If W, H or C is 0, IDLE → FINISH instead.
  - START (1 cycle): `o_conv_start`=1, `o_mem_en`=1, `o_mem_addr`=current address, address counter +1. Next state is STREAM.
  - STREAM (W*H cycles): `o_valid`=1 and `o_data`=`i_mem_rdata` every cycle. In each of the first W*H−1 cycles, `o_mem_en`=1 at the next address and the counter increments. After the last pixel the next state is WAIT_DONE.
  - WAIT_DONE: `i_conv_done` is sampled. When it is high, go to START if more planes remain, otherwise to FINISH. The plane counter decrements on this transition.
  - FINISH (1 cycle): `o_done`=1, then IDLE.
- `i_conv_done` is ignored outside WAIT_DONE. A done pulse arriving during START or STREAM is dropped; it does not advance a plane.
- `o_data` is 0 whenever `o_valid`=0, and `i_mem_rdata` is gated off.
- There is no backpressure. The stream is contiguous and never stalls inside a plane.
- Pixel-count counter is 18 bits (max 511*511). Plane counter is 10 bits.

## Timing
- Reset (`i_rst`=0 at a clock edge) forces, on the next cycle:
  - outputs `o_cmd_ready`=1, `o_mem_en`=0, `o_mem_addr`=0, `o_conv_start`=0, `o_data`=0, `o_valid`=0, `o_busy`=0, `o_done`=0;
  - state IDLE.
- Reset wins over everything, including mid-stream. The partial plane is abandoned with no `o_done`.
- Cycle numbering from accept at cycle T:
  - `o_conv_start` at T+1;
  - pixel k of plane 0 valid at T+2+k;
  - last pixel at T+1+W*H.
- After `i_conv_done` is seen at cycle D: the next START is at D+1, or FINISH (`o_done`) is at D+1.
- Minimum extra gap between planes is 2 cycles: 1 WAIT_DONE + 1 START, when done is already high on entering WAIT_DONE.
- Zero-size command accepted at T: `o_done` at T+1, with no start, no reads and no valid.
- `o_cmd_ready` returns high the cycle after FINISH. Back-to-back commands are therefore spaced by at least 1 IDLE cycle.

## Test plan
- **Single plane:** W=H=6, C=1, base=0, SRAM[a]=a.
  - Start at T+1; `o_data`=0..35 on T+2..T+37, contiguous.
  - `i_conv_done` at T+40 → `o_done` at T+41.
- **Multi-plane:** W=H=2, C=3, base=0x100, done returned 5 cycles after each last pixel.
  - Exactly 3 start pulses.
  - Addresses 0x100..0x10B in order.
  - `o_done` once, 1 cycle after the third done.
- **Early and held done:** pulse `i_conv_done` during STREAM, then hold it high.
  - The mid-stream pulse is ignored.
  - The held level advances each plane at the 2-cycle minimum gap.
- **Zero size:** W=0 (then C=0) → `o_done` at T+1; `o_mem_en` and `o_valid` never assert.
- **Reset mid-operation:** assert reset during pixel 10 of a 6x6 plane.
  - All outputs take reset values on the next cycle.
  - A new command then runs cleanly from its own base.
- **Address wrap:** base=2^20−4, W=H=2, C=2 → addresses FFFFC..FFFFF, then 00000..00003.

Source files
------------

// File: rtl/ifmap_streamer.sv
// Streams ifmap planes from a 1-cycle-latency SRAM into the conv core in raster order,
// issuing one conv start per plane and waiting for the core's done between planes.
module ifmap_streamer #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 20
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_cmd_valid,
    output logic                  o_cmd_ready,
    input  logic [ADDR_WIDTH-1:0] i_base_addr,
    input  logic [8:0]            i_width,
    input  logic [8:0]            i_height,
    input  logic [9:0]            i_num_ch,
    output logic                  o_mem_en,
    output logic [ADDR_WIDTH-1:0] o_mem_addr,
    input  logic [DATA_WIDTH-1:0] i_mem_rdata,
    output logic                  o_conv_start,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_valid,
    input  logic                  i_conv_done,
    output logic                  o_busy,
    output logic                  o_done,
    output logic [2:0]            o_state
);

    // Command handshake: a command is taken on any cycle where i_cmd_valid and
    // o_cmd_ready are both high; o_cmd_ready is high only while idle.
    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_START     = 3'd1,
        S_STREAM    = 3'd2,
        S_WAIT_DONE = 3'd3,
        S_FINISH    = 3'd4
    } state_t;

    state_t                  state;
    state_t                  state_next;
    logic [ADDR_WIDTH-1:0]   addr_cnt;
    logic [17:0]             plane_pixels;
    logic [17:0]             pix_left;
    logic [9:0]              ch_left;
    logic                    accept;
    logic                    zero_cmd;
    logic                    mem_en;
    logic                    valid;

    assign accept   = i_cmd_valid && (state == S_IDLE);
    assign zero_cmd = (i_width == 9'd0) || (i_height == 9'd0) || (i_num_ch == 10'd0);

    always_comb begin
        state_next   = state;
        o_cmd_ready  = 1'b0;
        mem_en       = 1'b0;
        o_conv_start = 1'b0;
        valid        = 1'b0;
        o_busy       = 1'b1;
        o_done       = 1'b0;
        case (state)
            S_IDLE: begin
                o_cmd_ready = 1'b1;
                o_busy      = 1'b0;
                if (accept) begin
                    state_next = zero_cmd ? S_FINISH : S_START;
                end
            end
            S_START: begin
                o_conv_start = 1'b1;
                mem_en       = 1'b1;
                state_next   = S_STREAM;
            end
            S_STREAM: begin
                // pix_left counts reads still owed; at zero this is the last pixel.
                valid = 1'b1;
                if (pix_left != 18'd0) begin
                    mem_en = 1'b1;
                end else begin
                    state_next = S_WAIT_DONE;
                end
            end
            S_WAIT_DONE: begin
                if (i_conv_done) begin
                    state_next = (ch_left == 10'd1) ? S_FINISH : S_START;
                end
            end
            S_FINISH: begin
                o_done     = 1'b1;
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    assign o_mem_en   = mem_en;
    assign o_mem_addr = mem_en ? addr_cnt : '0;
    assign o_valid    = valid;
    assign o_data     = valid ? i_mem_rdata : '0;
    assign o_state    = state;

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            state        <= S_IDLE;
            addr_cnt     <= '0;
            plane_pixels <= '0;
            pix_left     <= '0;
            ch_left      <= '0;
        end else begin
            state <= state_next;
            if (accept) begin
                addr_cnt     <= i_base_addr;
                plane_pixels <= {9'd0, i_width} * {9'd0, i_height};
                ch_left      <= i_num_ch;
            end else if (mem_en) begin
                addr_cnt <= addr_cnt + 1'b1;
            end
            if (state == S_START) begin
                pix_left <= plane_pixels - 18'd1;
            end else if (state == S_STREAM && pix_left != 18'd0) begin
                pix_left <= pix_left - 18'd1;
            end
            if (state == S_WAIT_DONE && i_conv_done) begin
                ch_left <= ch_left - 10'd1;
            end
        end
    end

endmodule
